// File: rtl/float_pkg.sv
// Shared constants and types for the float adder result path.
// Class codes, adder status codes, field widths and the FIFO entry bundle.
package float_pkg;

  localparam int unsigned FLT_W  = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;
  localparam int unsigned CLS_W  = 3;
  localparam int unsigned OVF_W  = 2;

  localparam logic [EXP_W-1:0] EXP_ZERO = 8'd0;
  localparam logic [EXP_W-1:0] EXP_MAX  = 8'd255;

  typedef enum logic [CLS_W-1:0] {
    CLS_ZERO      = 3'd0,
    CLS_SUBNORMAL = 3'd1,
    CLS_NORMAL    = 3'd2,
    CLS_INF       = 3'd3,
    CLS_NAN       = 3'd4
  } cls_e;

  typedef enum logic [OVF_W-1:0] {
    OVF_NONE    = 2'b00,
    OVF_OVER    = 2'b01,
    OVF_UNDER   = 2'b10,
    OVF_SPECIAL = 2'b11
  } ovf_e;

  typedef struct packed {
    logic [FLT_W-1:0] z;
    logic [OVF_W-1:0] ovf;
    logic [CLS_W-1:0] cls;
  } entry_t;

  function automatic logic [EXP_W-1:0] f_exp(
    input logic [FLT_W-1:0] v
  );
    return v[FLT_W-2 -: EXP_W];
  endfunction

  function automatic logic [MANT_W-1:0] f_mant(
    input logic [FLT_W-1:0] v
  );
    return v[MANT_W-1:0];
  endfunction

endpackage

// File: rtl/float_classify.sv
// Combinational IEEE-754 single classifier, sign ignored.
// Ports: z (32-bit value) -> cls (3-bit class code).
module float_classify
  import float_pkg::*;
(
  input  logic [FLT_W-1:0] z,
  output logic [CLS_W-1:0] cls
);

  logic [EXP_W-1:0]  e;
  logic [MANT_W-1:0] m;
  logic              e_zero;
  logic              e_max;
  logic              m_zero;

  assign e      = f_exp(z);
  assign m      = f_mant(z);
  assign e_zero = (e == EXP_ZERO);
  assign e_max  = (e == EXP_MAX);
  assign m_zero = (m == '0);

  always_comb begin
    cls = CLS_NORMAL;
    unique case (1'b1)
      e_zero &&  m_zero: cls = CLS_ZERO;
      e_zero && !m_zero: cls = CLS_SUBNORMAL;
      e_max  &&  m_zero: cls = CLS_INF;
      e_max  && !m_zero: cls = CLS_NAN;
      default:           cls = CLS_NORMAL;
    endcase
  end

endmodule

// File: rtl/float_result_fifo.sv
// Result stage: classifies adder sums into a FWFT FIFO, keeps sticky flags.
// Ports: in_valid/in_z/in_ovf in; out_* valid/ready head; count/full/sticky/drop status.
module float_result_fifo
  import float_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [FLT_W-1:0]             in_z,
  input  logic [OVF_W-1:0]             in_ovf,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [FLT_W-1:0]             out_z,
  output logic [OVF_W-1:0]             out_ovf,
  output logic [CLS_W-1:0]             out_class,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic [2:0]                   sticky_flags,
  input  logic                         sticky_clr,
  output logic [CNT_W-1:0]             drop_cnt
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CLS_W-1:0] in_cls;
  entry_t          head;
  entry_t          wr_ent;
  logic            pop;
  logic            push;
  logic            drop;
  logic [2:0]      sticky_set;
  logic [2:0]      sticky_nxt;

  float_classify u_cls (
    .z   (in_z),
    .cls (in_cls)
  );

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & (~full | pop);
  assign drop      = in_valid & full & ~pop;

  assign wr_ent.z   = in_z;
  assign wr_ent.ovf = in_ovf;
  assign wr_ent.cls = in_cls;

  // Head fields are forced to zero when empty so stale slots never leak.
  assign head      = mem[rd_ptr];
  assign out_z     = out_valid ? head.z   : '0;
  assign out_ovf   = out_valid ? head.ovf : '0;
  assign out_class = out_valid ? head.cls : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_ent;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Flags track every strobe, including dropped ones.
  always_comb begin
    sticky_set = '0;
    if (in_valid) begin
      unique case (in_ovf)
        OVF_OVER:    sticky_set = 3'b001;
        OVF_UNDER:   sticky_set = 3'b010;
        OVF_SPECIAL: sticky_set = 3'b100;
        default:     sticky_set = 3'b000;
      endcase
    end
  end

  // Clear first, then OR in this cycle's set so a set wins over clear.
  assign sticky_nxt = (sticky_clr ? 3'b000 : sticky_flags) | sticky_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= '0;
    end else begin
      sticky_flags <= sticky_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_float_result_fifo.sv
// Randomized + directed bench for float_result_fifo against a queue model.
// Prints one summary line with error and check counts.
module tb_float_result_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CW    = $clog2(DEPTH+1);

  typedef struct packed {
    logic [31:0] z;
    logic [1:0]  ovf;
    logic [2:0]  cls;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_z = '0;
  logic [1:0]       in_ovf = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_z;
  logic [1:0]       out_ovf;
  logic [2:0]       out_class;
  logic [CW-1:0]    count;
  logic             full;
  logic [2:0]       sticky_flags;
  logic             sticky_clr = 1'b0;
  logic [CNT_W-1:0] drop_cnt;

  float_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_z         (in_z),
    .in_ovf       (in_ovf),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_z        (out_z),
    .out_ovf      (out_ovf),
    .out_class    (out_class),
    .count        (count),
    .full         (full),
    .sticky_flags (sticky_flags),
    .sticky_clr   (sticky_clr),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  int   n_err = 0;
  int   n_chk = 0;
  ent_t q[$];
  int   m_drop = 0;
  logic [2:0] m_sticky = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_class(input logic [31:0] v);
    int e;
    int m;
    e = int'(v[30:23]);
    m = int'(v[22:0]);
    if (e == 0)   return (m == 0) ? 3'd0 : 3'd1;
    if (e == 255) return (m == 0) ? 3'd3 : 3'd4;
    return 3'd2;
  endfunction

  task automatic check_all();
    ent_t h;
    h = (q.size() != 0) ? q[0] : '0;
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("count", 32'(count), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("out_z", out_z, h.z);
    check("out_ovf", 32'(out_ovf), 32'(h.ovf));
    check("out_class", 32'(out_class), 32'(h.cls));
    check("sticky", 32'(sticky_flags), 32'(m_sticky));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  // Drive one cycle, advance the model on the edge, then compare.
  task automatic step(input logic v, input logic [31:0] z,
                      input logic [1:0] o, input logic rdy,
                      input logic clr);
    bit   pop;
    bit   push;
    bit   isfull;
    ent_t e;
    in_valid   = v;
    in_z       = z;
    in_ovf     = o;
    out_ready  = rdy;
    sticky_clr = clr;
    isfull = (q.size() == DEPTH);
    pop    = (q.size() != 0) && rdy;
    push   = v && (!isfull || pop);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      e.z = z; e.ovf = o; e.cls = ref_class(z);
      q.push_back(e);
    end
    if (v && isfull && !pop && m_drop < 255) m_drop++;
    if (clr) m_sticky = '0;
    if (v && o != 2'b00) m_sticky[int'(o) - 1] = 1'b1;
    #1;
    check_all();
  endtask

  function automatic logic [31:0] rand_z();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r[30:0] = '0;
      1: r[30:23] = 8'd0;
      2: r[30:23] = 8'd255;
      3: begin r[30:23] = 8'd255; r[22:0] = '0; end
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    #12;
    check_all();
    rst_n = 1'b1;
    @(posedge clk); #1;

    step(1, 32'h3F800000, 2'b00, 0, 0);
    check("tp1_class", 32'(out_class), 32'd2);
    step(0, '0, 2'b00, 1, 0);

    step(1, 32'h00000001, 2'b00, 1, 0);
    step(1, 32'h7F800000, 2'b00, 1, 0);
    step(1, 32'h7FC00000, 2'b00, 1, 0);
    step(1, 32'h80000000, 2'b00, 1, 0);
    step(0, '0, 2'b00, 1, 0);
    check("tp2_count", 32'(count), 32'd0);

    for (int i = 0; i < DEPTH; i++)
      step(1, 32'h40000000 + 32'(i), 2'b00, 0, 0);
    for (int i = 0; i < 3; i++)
      step(1, 32'h41000000 + 32'(i), 2'b01, 0, 0);
    check("tp3_full", 32'(full), 32'd1);
    check("tp3_drop", 32'(drop_cnt), 32'd3);
    check("tp3_sticky", 32'(sticky_flags), 32'd1);
    check("tp3_head", out_z, 32'h40000000);

    step(1, 32'h42000000, 2'b00, 1, 0);
    check("tp4_count", 32'(count), 32'd4);
    check("tp4_drop", 32'(drop_cnt), 32'd3);
    check("tp4_head", out_z, 32'h40000001);

    step(1, 32'h42800000, 2'b11, 0, 0);
    check("tp5_pre", 32'(sticky_flags), 32'd5);
    step(1, 32'h43000000, 2'b10, 0, 1);
    check("tp5_clr", 32'(sticky_flags), 32'd2);

    for (int i = 0; i < 300; i++)
      step(1, rand_z(), 2'($urandom), 0, 0);
    check("sat_drop", 32'(drop_cnt), 32'd255);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 6, rand_z(), 2'($urandom),
           $urandom_range(0, 9) < 5, $urandom_range(0, 19) == 0);

    while (q.size() != 3) begin
      if (q.size() > 3) step(0, '0, 2'b00, 1, 0);
      else step(1, rand_z(), 2'b01, 0, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_drop = 0;
    m_sticky = '0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 32'hC0490FDB, 2'b00, 0, 0);
    check("post_rst_z", out_z, 32'hC0490FDB);
    step(0, '0, 2'b00, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
